// File: rtl/bitsim_pkg.sv
// Shared types and widths for the bit-serial datapath blocks.
//   sched_state_t : scheduler FSM states
//   MASK_W        : essential-bit mask width (fixed at 5, tied to the 5-to-3 encoder)
//   SHIFT_W       : shift / beat-index width (= $clog2(MASK_W+1))
package bitsim_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam int MASK_W  = 5;
    localparam int SHIFT_W = 3;

endpackage

// File: rtl/pencoder_5to3.sv
// 5-to-3 leading-one priority encoder, MSB first.
// Ports:
//   in  [4:0] : mask to encode
//   out [2:0] : position of leading set bit as a shift (bit4->0 ... bit0->4),
//               0 when in is all-zero
//   val       : any bit of in is set
module pencoder_5to3
    import bitsim_pkg::*;
(
    input  logic [MASK_W-1:0]  in,
    output logic [SHIFT_W-1:0] out,
    output logic               val
);

    always_comb begin
        out = '0;
        val = |in;
        if      (in[4]) out = 3'd0;
        else if (in[3]) out = 3'd1;
        else if (in[2]) out = 3'd2;
        else if (in[1]) out = 3'd3;
        else if (in[0]) out = 3'd4;
    end

endmodule

// File: rtl/bitmask_serial_scheduler.sv
// Walks a 5-bit essential-bit mask one set bit per cycle, MSB first, and
// issues the shift for each set bit to the bit-serial shift-add PE.
// A zero mask produces a single skip beat (out_zero=1, out_last=1).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous flush back to IDLE (highest priority)
//   in_mask      : essential-bit mask, bit4 = MSB = shift 0
//   in_valid     : in_mask valid
//   in_ready     : a mask can be accepted this cycle
//   out_shift    : shift for the current beat
//   out_idx      : 0-based beat index within the current mask
//   out_zero     : current mask is all-zero (skip beat)
//   out_last     : final beat of the current mask
//   out_valid    : beat valid
//   out_ready    : PE accepts the beat
module bitmask_serial_scheduler
    import bitsim_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [MASK_W-1:0]  in_mask,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [SHIFT_W-1:0] out_shift,
    output logic [SHIFT_W-1:0] out_idx,
    output logic               out_zero,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready
);

    sched_state_t       state;
    logic [MASK_W-1:0]  mask_q;
    logic [SHIFT_W-1:0] idx_q;

    logic [SHIFT_W-1:0] enc_shift;
    logic               enc_val;
    logic               run;
    logic               last;
    logic               fire;
    logic               accept;
    logic [MASK_W-1:0]  mask_strip;

    pencoder_5to3 u_enc (
        .in  (mask_q),
        .out (enc_shift),
        .val (enc_val)
    );

    assign run  = (state == RUN);
    // Single-bit and zero masks both end on the current beat.
    assign last = ((mask_q & (mask_q - MASK_W'(1))) == '0);
    // Drop the bit this beat consumed.
    assign mask_strip = mask_q & ~(MASK_W'(5'b10000) >> enc_shift);

    assign out_valid = run;
    assign out_shift = run ? enc_shift : '0;
    assign out_idx   = run ? idx_q : '0;
    assign out_zero  = run && (mask_q == '0);
    assign out_last  = run && last;

    assign fire     = out_valid && out_ready;
    // Accepting on the last fire lets back-to-back masks run without a bubble.
    assign in_ready = ((state == IDLE) || (fire && last)) && !clear;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask_q <= '0;
            idx_q  <= '0;
        end else if (clear) begin
            state  <= IDLE;
            mask_q <= '0;
            idx_q  <= '0;
        end else if (accept) begin
            state  <= RUN;
            mask_q <= in_mask;
            idx_q  <= '0;
        end else if (fire) begin
            if (last) begin
                state  <= IDLE;
                mask_q <= '0;
                idx_q  <= '0;
            end else begin
                mask_q <= mask_strip;
                idx_q  <= idx_q + SHIFT_W'(1);
            end
        end
    end

    // Encoder valid must agree with the zero-mask decode used for out_zero.
    a_enc_val: assert property (@(posedge clk) disable iff (!rst_n)
        enc_val == (mask_q != '0));

endmodule

// File: tb/tb_bitmask_serial_scheduler.sv
module tb_bitmask_serial_scheduler;
    import bitsim_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic [MASK_W-1:0]  in_mask;
    logic               in_valid;
    logic               in_ready;
    logic [SHIFT_W-1:0] out_shift;
    logic [SHIFT_W-1:0] out_idx;
    logic               out_zero;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bitmask_serial_scheduler dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_mask(in_mask), .in_valid(in_valid), .in_ready(in_ready),
        .out_shift(out_shift), .out_idx(out_idx), .out_zero(out_zero),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic       iv;
        logic [4:0] mask;
        logic       ordy;
        logic       clr;
        logic       ov;
        logic [2:0] sh;
        logic [2:0] idx;
        logic       z;
        logic       l;
        logic       ir;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output; shift/idx/zero/last only matter while out_valid.
    task automatic check_all(input string tag, input vec_t v);
        chk({tag, ".out_valid"}, 8'(out_valid), 8'(v.ov));
        chk({tag, ".in_ready"},  8'(in_ready),  8'(v.ir));
        chk({tag, ".out_shift"}, 8'(out_shift), 8'(v.sh));
        chk({tag, ".out_idx"},   8'(out_idx),   8'(v.idx));
        chk({tag, ".out_zero"},  8'(out_zero),  8'(v.z));
        chk({tag, ".out_last"},  8'(out_last),  8'(v.l));
    endtask

    // Drive inputs after the falling edge, sample 1ns later (well clear of posedge).
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        in_valid  = v.iv;
        in_mask   = v.mask;
        out_ready = v.ordy;
        clear     = v.clr;
        #1;
        check_all(tag, v);
    endtask

    function automatic vec_t mk(input logic iv, input logic [4:0] m, input logic ordy,
                                input logic clr, input logic ov, input logic [2:0] sh,
                                input logic [2:0] idx, input logic z, input logic l,
                                input logic ir);
        vec_t v;
        v.iv = iv; v.mask = m; v.ordy = ordy; v.clr = clr;
        v.ov = ov; v.sh = sh; v.idx = idx; v.z = z; v.l = l; v.ir = ir;
        return v;
    endfunction

    vec_t tbl[$];
    vec_t idle_v;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_mask = '0; in_valid = 1'b0; out_ready = 1'b1;
        idle_v = mk(0, 5'b0, 1, 0, 0, 0, 0, 0, 0, 1);

        // Reset state
        #3;
        check_all("reset", idle_v);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        //             iv  mask     ordy clr  ov sh idx z  l  ir
        // 10110 -> shifts 0,2,3
        tbl.push_back(mk(1, 5'b10110, 1, 0,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 3, 2, 0, 1, 1));
        // zero mask: single skip beat
        tbl.push_back(mk(1, 5'b00000, 1, 0,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 0, 0, 1, 1, 1));
        // 00001 then 11111 back to back
        tbl.push_back(mk(1, 5'b00001, 1, 0,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 5'b11111, 1, 0,  1, 4, 0, 0, 1, 1));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 2, 2, 0, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 3, 3, 0, 0, 0));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  1, 4, 4, 0, 1, 1));
        tbl.push_back(mk(0, 5'b00000, 1, 0,  0, 0, 0, 0, 0, 1));

        foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

        // Stall: 01010, out_ready low for 3 cycles on the first beat
        step("st_acc", mk(1, 5'b01010, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++)
            step($sformatf("st_hold%0d", k), mk(0, 5'b0, 0, 0, 1, 1, 0, 0, 0, 0));
        step("st_b0",  mk(0, 5'b0, 1, 0, 1, 1, 0, 0, 0, 0));
        step("st_b1",  mk(0, 5'b0, 1, 0, 1, 3, 1, 0, 1, 1));
        step("st_end", idle_v);

        // clear during the 2nd beat of 11100; in_valid high must not be taken
        step("cl_acc", mk(1, 5'b11100, 1, 0, 0, 0, 0, 0, 0, 1));
        step("cl_b0",  mk(0, 5'b0, 1, 0, 1, 0, 0, 0, 0, 0));
        step("cl_b1",  mk(1, 5'b00011, 1, 1, 1, 1, 1, 0, 0, 0));
        step("cl_p0",  idle_v);
        step("cl_p1",  idle_v);

        // Async reset mid-RUN, asserted between edges
        step("rs_acc", mk(1, 5'b00111, 1, 0, 0, 0, 0, 0, 0, 1));
        step("rs_b0",  mk(0, 5'b0, 0, 0, 1, 2, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rs_async", idle_v);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            step($sformatf("rs_post%0d", k), idle_v);
        // A fresh accept works after reset
        step("rs_acc2", mk(1, 5'b01000, 1, 0, 0, 0, 0, 0, 0, 1));
        step("rs_b",    mk(0, 5'b0, 1, 0, 1, 1, 0, 0, 1, 1));
        step("rs_end",  idle_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "timeout");
    end

endmodule
